// File: rtl/battleship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : battleship_pkg
// Description : Shared sizes, FSM encoding and result/cell codes for the
//               battleship shot tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package battleship_pkg;

  localparam int GRIDSIZE_DEF = 5;
  localparam int CELLS_DEF    = GRIDSIZE_DEF * GRIDSIZE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CHECK  = 2'b01,
    ST_REPORT = 2'b10,
    ST_OVER   = 2'b11
  } state_t;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_HIT     = 2'b01;
  localparam logic [1:0] RES_REPEAT  = 2'b10;
  localparam logic [1:0] RES_INVALID = 2'b11;

  localparam logic [1:0] CELL_UNSHOT = 2'b00;
  localparam logic [1:0] CELL_MISS   = 2'b01;
  localparam logic [1:0] CELL_HIT    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/shot_tracker_popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Combinational count of set bits in the ship map.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount
  import battleship_pkg::*;
#(
  parameter int GRIDSIZE = GRIDSIZE_DEF,
  parameter int CELLS    = GRIDSIZE * GRIDSIZE
) (
  input  logic [CELLS-1:0]    bits,
  output logic [GRIDSIZE-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CELLS; i++) begin
      count = count + {{(GRIDSIZE-1){1'b0}}, bits[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/shot_tracker.sv
`default_nettype none
// ============================================================================
// Module      : shot_tracker
// Description : Scores shots against a latched ship map, tracks hit/miss
//               cells per game and serves per-cell state to the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module shot_tracker
  import battleship_pkg::*;
#(
  parameter int GRIDSIZE = GRIDSIZE_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [GRIDSIZE*GRIDSIZE-1:0]   ship_map,
  input  logic                           fire,
  input  logic [GRIDSIZE-1:0]            coord,
  input  logic [GRIDSIZE-1:0]            query_idx,
  output logic [1:0]                     query_state,
  output logic                           busy,
  output logic                           result_valid,
  output logic [1:0]                     result_code,
  output logic [GRIDSIZE-1:0]            hit_count,
  output logic                           game_over
);

  localparam int CELLS = GRIDSIZE * GRIDSIZE;
  localparam logic [GRIDSIZE:0]   c_cells_ext = (GRIDSIZE+1)'(CELLS);
  localparam logic [GRIDSIZE-1:0] c_hit_max   = GRIDSIZE'(CELLS);

  state_t               r_state;
  logic [GRIDSIZE-1:0]  r_shot_idx;
  logic [CELLS-1:0]     r_hit_map;
  logic [CELLS-1:0]     r_miss_map;
  logic [CELLS-1:0]     r_ship_reg;
  logic [GRIDSIZE-1:0]  r_ship_total;
  // Set by start; an un-started (post-reset) board never ends the game.
  logic                 r_loaded;

  logic [GRIDSIZE-1:0]  w_pop;
  logic                 w_shot_ok;
  logic                 w_query_ok;
  logic [1:0]           w_code;
  logic [1:0]           w_query_state;

  popcount #(
    .GRIDSIZE (GRIDSIZE),
    .CELLS    (CELLS)
  ) u_popcount (
    .bits  (ship_map),
    .count (w_pop)
  );

  assign w_shot_ok  = ({1'b0, r_shot_idx} < c_cells_ext);
  assign w_query_ok = ({1'b0, query_idx}  < c_cells_ext);

  always_comb begin
    w_code = RES_MISS;
    if (!w_shot_ok) begin
      w_code = RES_INVALID;
    end else if (r_hit_map[r_shot_idx] || r_miss_map[r_shot_idx]) begin
      w_code = RES_REPEAT;
    end else if (r_ship_reg[r_shot_idx]) begin
      w_code = RES_HIT;
    end
  end

  always_comb begin
    w_query_state = CELL_UNSHOT;
    if (w_query_ok) begin
      if (r_hit_map[query_idx]) begin
        w_query_state = CELL_HIT;
      end else if (r_miss_map[query_idx]) begin
        w_query_state = CELL_MISS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shot_idx   <= '0;
      r_hit_map    <= '0;
      r_miss_map   <= '0;
      r_ship_reg   <= '0;
      r_ship_total <= '0;
      r_loaded     <= 1'b0;
      hit_count    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_code  <= RES_MISS;
      query_state  <= CELL_UNSHOT;
      game_over    <= 1'b0;
    end else begin
      query_state  <= w_query_state;
      result_valid <= 1'b0;
      if (start) begin
        // A new game also abandons any shot still in flight.
        r_state      <= ST_IDLE;
        r_hit_map    <= '0;
        r_miss_map   <= '0;
        r_ship_reg   <= ship_map;
        r_ship_total <= w_pop;
        r_loaded     <= 1'b1;
        hit_count    <= '0;
        busy         <= 1'b0;
        game_over    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_loaded && (r_ship_total == '0)) begin
              r_state   <= ST_OVER;
              game_over <= 1'b1;
            end else if (fire) begin
              r_shot_idx <= coord;
              r_state    <= ST_CHECK;
              busy       <= 1'b1;
            end
          end
          ST_CHECK: begin
            if (w_code == RES_HIT) begin
              r_hit_map[r_shot_idx] <= 1'b1;
              if (hit_count != c_hit_max) begin
                hit_count <= hit_count + 1'b1;
              end
            end else if (w_code == RES_MISS) begin
              r_miss_map[r_shot_idx] <= 1'b1;
            end
            result_code  <= w_code;
            result_valid <= 1'b1;
            r_state      <= ST_REPORT;
          end
          ST_REPORT: begin
            busy <= 1'b0;
            if (r_loaded && (hit_count == r_ship_total)) begin
              r_state   <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_OVER;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/shot_tracker.md
SHOT_TRACKER -- requirements
Module: shot_tracker

Interface
REQ-001 Parameter GRIDSIZE, default 5: grid side length; cell count CELLS = GRIDSIZE*GRIDSIZE (25); coord width GRIDSIZE bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; latches ship_map and begins a new game.
REQ-005 ship_map  in  CELLS  bit i = 1 means a ship occupies linear cell i (i = row*GRIDSIZE + col).
REQ-006 fire  in  1  one-cycle shot request; the cursor's center press.
REQ-007 coord  in  GRIDSIZE  linear cell index from the cursor block, sampled with fire.
REQ-008 query_idx  in  GRIDSIZE  cell index from the VGA renderer.
REQ-009 query_state  out  2  registered state of cell query_idx: 00 unshot, 01 miss, 10 hit, 11 never driven.
REQ-010 busy  out  1  high while a shot is in flight (CHECK, REPORT).
REQ-011 result_valid  out  1  one-cycle pulse per accepted fire.
REQ-012 result_code  out  2  00 miss, 01 hit, 10 repeat, 11 invalid; valid only with result_valid.
REQ-013 hit_count  out  GRIDSIZE  number of distinct cells hit this game.
REQ-014 game_over  out  1  high once every ship cell has been hit.

Function
REQ-015 FSM states: IDLE, CHECK, REPORT, OVER.
REQ-016 IDLE: fire=1 latches coord into shot_idx; next state is CHECK.
REQ-017 CHECK: compute one of the following, then go to REPORT:
- coord >= CELLS: invalid.
- cell already in hit_map or miss_map: repeat.
- ship_map bit set: hit.
- otherwise: miss.
REQ-018 CHECK updates, registered at the end of CHECK:
- hit: set hit_map[shot_idx]; increment hit_count.
- miss: set miss_map[shot_idx].
- repeat or invalid: no map or count change.
REQ-019 REPORT: result_valid=1 and result_code driven; next state is OVER if hit_count == ship_total, else IDLE.
REQ-020 Latency: fire in cycle N gives result_valid in cycle N+2; the next fire is accepted no earlier than cycle N+3.
REQ-021 fire while busy=1 or in OVER is ignored: no latch, no result, no state change.
REQ-022 start in any state, reset excepted:
- clear hit_map, miss_map and hit_count;
- latch ship_map into ship_reg;
- load ship_total = popcount(ship_map);
- go to IDLE.
- start takes priority over a simultaneous fire.
REQ-023 ship_total = 0 after start: state goes to OVER on the next cycle; game_over=1.
REQ-024 game_over = (state == OVER); OVER exits only on start or reset.
REQ-025 query_state updates each cycle from query_idx with 1-cycle latency; query_idx >= CELLS returns 00.
REQ-026 hit_count saturates at CELLS; it never wraps.
REQ-027 ship_map changes are ignored except in the cycle start=1.

Reset
REQ-028 reset=1 at a clock edge produces:
- state IDLE;
- hit_map, miss_map, ship_reg and ship_total = 0;
- hit_count = 0, busy = 0, result_valid = 0, result_code = 00, query_state = 00;
- game_over = 0.
REQ-029 Reset has priority over start and fire, including mid-shot (CHECK or REPORT): the in-flight shot is discarded and no result_valid is issued.
REQ-030 After reset with no start, shots are scored against an all-zero ship map: every valid shot is a miss.

Structure
REQ-031 Shared package battleship_pkg holds:
- GRIDSIZE default and CELLS;
- FSM state encodings;
- result_code constants (RES_MISS, RES_HIT, RES_REPEAT, RES_INVALID);
- cell-state constants.
REQ-032 One sub-module, popcount (combinational, CELLS-bit input, GRIDSIZE-bit output), computes ship_total; all other logic is inline.

Verification
REQ-033 The bench shall cover these directed scenarios:
- Reset, then start with ship_map=25'h0000003 (cells 0,1); fire coord=0 -> result_valid at +2 cycles, code 01, hit_count=1, query_state(0)=10.
- Same game, fire coord=0 again -> code 10, hit_count stays 1; fire coord=7 -> code 00, query_state(7)=01.
- Fire coord=25 -> code 11, no map change; fire coord=1 -> code 01, hit_count=2, game_over=1; further fire -> no result_valid.
- Fire on two consecutive cycles -> exactly one result_valid, for the first coord only.
- Reset asserted in CHECK -> no result_valid, all outputs 0 next cycle; start while in OVER -> game_over=0, maps cleared.
- start with ship_map=0 -> game_over=1 within 1 cycle; start and fire in the same cycle -> fire ignored.
